exec_stage_mc: RTL and testbench
================================

EXEC_STAGE_MC -- requirements
Module: exec_stage_mc

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be a power of two, 8..64.
REQ-002 Parameter TAG_W, default 6, width of the opaque tag carried with each operation.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_flush  input  1  synchronous kill of any in-flight or held operation.
REQ-006 i_valid  input  1  issue side offers an operation.
REQ-007 o_ready  output  1  block can accept an operation this cycle.
REQ-008 i_op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULHU, 12-15 reserved.
REQ-009 i_op1, i_op2  input  XLEN each  source operands.
REQ-010 i_tag  input  TAG_W  tag passed through unchanged.
REQ-011 o_valid  output  1  result available.
REQ-012 i_ready  input  1  downstream accepts result this cycle.
REQ-013 o_result  output  XLEN  result; o_tag  output  TAG_W  tag of that result.

Function
REQ-014 Transfer in occurs when i_valid && o_ready; transfer out occurs when o_valid && i_ready.
REQ-015 FSM SHALL have states IDLE, BUSY, DONE; exactly one operation in flight.
REQ-016 o_ready SHALL be 1 in IDLE, 1 in DONE when i_ready is 1, else 0; SHALL be 0 when i_flush is 1.
REQ-017 Ops 0-9 accepted: result computed combinationally from inputs, registered; next state DONE; latency 1 cycle.
REQ-018 Shifts use op2[log2(XLEN)-1:0] only; SRA sign-fills; SLT signed compare, SLTU unsigned; compare results zero-extended to XLEN.
REQ-019 ADD/SUB wrap modulo 2^XLEN; no overflow flag.
REQ-020 Ops 10-11 accepted: next state BUSY; iterative shift-add on a 2*XLEN product register, one multiplier bit per cycle, iteration counter log2(XLEN)+1 bits.
REQ-021 BUSY SHALL last exactly XLEN cycles, then DONE; accept-to-o_valid latency XLEN+1 cycles.
REQ-022 MUL result = low XLEN bits of op1*op2; MULHU = high XLEN bits of unsigned product.
REQ-023 Reserved opcodes SHALL complete in 1 cycle with o_result = 0.
REQ-024 In DONE, o_valid = 1; o_result and o_tag SHALL hold stable until transfer out.
REQ-025 DONE with transfer out and simultaneous transfer in: new op loaded same edge (back-to-back, no bubble); else DONE with transfer out -> IDLE.
REQ-026 In IDLE and BUSY, o_valid = 0; o_result/o_tag don't-care but SHALL not toggle X.
REQ-027 i_flush SHALL force o_valid = 0 combinationally and next state IDLE, discarding any BUSY or DONE op; a concurrent i_valid is not accepted.
REQ-028 rst has priority over i_flush; i_flush over all handshakes.

Reset
REQ-029 On rst: state IDLE, counter 0, product register 0, result register 0, tag register 0; o_valid = 0, o_ready = 1 in the first cycle after rst deasserts.
REQ-030 rst asserted mid-BUSY or mid-DONE SHALL abandon the operation with no result ever presented.

Verification
REQ-031 XLEN=32: ADD 0xFFFFFFFF+1, i_ready=1 -> o_valid next cycle, o_result 0x00000000, tag echoed.
REQ-032 SRA 0x80000000 by op2=0x24 -> shift 4, o_result 0xF8000000; SLT 0xFFFFFFFF<1 -> 1; SLTU -> 0.
REQ-033 MUL 0xFFFFFFFF*0xFFFFFFFF -> o_valid exactly 33 cycles after accept, o_result 0x00000001; MULHU same operands -> 0xFFFFFFFE; o_ready 0 throughout BUSY.
REQ-034 Result held with i_ready=0 for 5 cycles -> o_result/o_tag stable, o_ready 0; then i_ready=1 with i_valid=1 ADD -> new result next cycle, no bubble.
REQ-035 i_flush at BUSY cycle 10 of a MUL -> o_valid never asserts for it; o_ready 1 next cycle; following ADD 2+3 -> 5.
REQ-036 rst asserted in DONE with i_ready=0 -> o_valid 0 next cycle, o_ready 1 after deassert; random mixed-op stream vs reference model with random i_ready -> all results and tags match in order.

Source files
------------

// File: rtl/exec_stage_mc.sv
// Multi-cycle execute stage.
// One operation is in flight at a time. ALU operations (0-9) and reserved
// opcodes finish in one cycle. MUL and MULHU (10, 11) run an XLEN-cycle
// shift-add loop on a 2*XLEN product register. Results are held in DONE
// until the downstream accepts them.
module exec_stage_mc #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_op,
  input  logic [XLEN-1:0]  i_op1,
  input  logic [XLEN-1:0]  i_op2,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_tag
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [2*XLEN-1:0]   prod_q;
  logic [XLEN-1:0]     mcand_q;
  logic                hi_q;
  logic [XLEN-1:0]     result_q;
  logic [TAG_W-1:0]    tag_q;

  logic [XLEN-1:0]     alu_res_d;
  logic [XLEN:0]       mul_sum_d;
  logic [2*XLEN-1:0]   prod_d;
  logic [XLEN-1:0]     mul_res_d;
  logic [SHW-1:0]      shamt;
  logic                is_mul;
  logic                accept;
  logic                xfer_out;

  // Handshake: DONE may accept a new op only in the same cycle its result
  // leaves; a flush blocks both directions.
  assign o_valid  = (state_q == S_DONE) && !i_flush;
  assign o_ready  = !i_flush && ((state_q == S_IDLE) ||
                                 ((state_q == S_DONE) && i_ready));
  assign accept   = i_valid && o_ready;
  assign xfer_out = o_valid && i_ready;
  assign o_result = result_q;
  assign o_tag    = tag_q;

  assign shamt  = i_op2[SHW-1:0];
  assign is_mul = (i_op == 4'd10) || (i_op == 4'd11);

  // Single-cycle ALU result from the issue-side operands; reserved ops give 0.
  always_comb begin
    alu_res_d = {XLEN{1'b0}};
    case (i_op)
      4'd0:    alu_res_d = i_op1 + i_op2;
      4'd1:    alu_res_d = i_op1 - i_op2;
      4'd2:    alu_res_d = i_op1 & i_op2;
      4'd3:    alu_res_d = i_op1 | i_op2;
      4'd4:    alu_res_d = i_op1 ^ i_op2;
      4'd5:    alu_res_d = i_op1 << shamt;
      4'd6:    alu_res_d = i_op1 >> shamt;
      4'd7:    alu_res_d = $unsigned($signed(i_op1) >>> shamt);
      4'd8:    alu_res_d = {{(XLEN-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
      4'd9:    alu_res_d = {{(XLEN-1){1'b0}}, (i_op1 < i_op2)};
      default: alu_res_d = {XLEN{1'b0}};
    endcase
  end

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit (prod_q[0]) is set, then shift the whole register
  // right, keeping the carry as the new top bit.
  always_comb begin
    if (prod_q[0]) begin
      mul_sum_d = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
    end else begin
      mul_sum_d = {1'b0, prod_q[2*XLEN-1:XLEN]};
    end
    prod_d = {mul_sum_d, prod_q[XLEN-1:1]};
    if (hi_q) begin
      mul_res_d = prod_d[2*XLEN-1:XLEN];
    end else begin
      mul_res_d = prod_d[XLEN-1:0];
    end
  end

  // Control FSM and datapath registers; reset beats flush, flush beats handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      prod_q   <= {(2*XLEN){1'b0}};
      mcand_q  <= {XLEN{1'b0}};
      hi_q     <= 1'b0;
      result_q <= {XLEN{1'b0}};
      tag_q    <= {TAG_W{1'b0}};
    end else if (i_flush) begin
      state_q <= S_IDLE;
    end else if (accept) begin
      tag_q <= i_tag;
      if (is_mul) begin
        state_q <= S_BUSY;
        cnt_q   <= {CW{1'b0}};
        prod_q  <= {{XLEN{1'b0}}, i_op2};
        mcand_q <= i_op1;
        hi_q    <= (i_op == 4'd11);
      end else begin
        state_q  <= S_DONE;
        result_q <= alu_res_d;
      end
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_IDLE;
        S_BUSY: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            result_q <= mul_res_d;
            state_q  <= S_DONE;
          end else begin
            state_q <= S_BUSY;
          end
        end
        S_DONE: begin
          if (xfer_out) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_stage_mc.sv
// Self-checking bench for exec_stage_mc (XLEN=32, TAG_W=6): directed literal
// cases followed by a randomized stream checked cycle by cycle against a
// transaction-level reference model.
module tb_exec_stage_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_op;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic [5:0]  i_tag;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic [5:0]  o_tag;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  exec_stage_mc #(.XLEN(32), .TAG_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_flush  (i_flush),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_op1    (i_op1),
    .i_op2    (i_op2),
    .i_tag    (i_tag),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_tag    (o_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // Reference result straight from the opcode definitions.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:    ref_alu = a + b;
      4'd1:    ref_alu = a - b;
      4'd2:    ref_alu = a & b;
      4'd3:    ref_alu = a | b;
      4'd4:    ref_alu = a ^ b;
      4'd5:    ref_alu = a << b[4:0];
      4'd6:    ref_alu = a >> b[4:0];
      4'd7:    ref_alu = $unsigned($signed(a) >>> b[4:0]);
      4'd8:    ref_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    ref_alu = (a < b) ? 32'd1 : 32'd0;
      4'd10:   ref_alu = p[31:0];
      4'd11:   ref_alu = p[63:32];
      default: ref_alu = 32'd0;
    endcase
  endfunction

  // Transaction model: one op held with the cycle number at which it appears.
  int          cyc = 0;
  bit          m_has = 1'b0;
  logic [31:0] m_res = 32'd0;
  logic [5:0]  m_tag = 6'd0;
  int          m_due = 0;
  bit          n_has = 1'b0;
  logic [31:0] n_res = 32'd0;
  logic [5:0]  n_tag = 6'd0;
  int          n_due = 0;

  // Compare DUT outputs with the model mid-cycle and work out the model's next state.
  always @(negedge clk) begin : cmp
    bit          ev;
    bit          er;
    bit          h;
    logic [31:0] r;
    logic [5:0]  t;
    int          d;
    ev = m_has && (cyc >= m_due) && !i_flush;
    er = !i_flush && (!m_has || (ev && i_ready));
    if (chk_en && !rst) begin
      chk("model_o_valid", {63'd0, o_valid}, {63'd0, ev});
      chk("model_o_ready", {63'd0, o_ready}, {63'd0, er});
      if (ev) begin
        chk("model_o_result", {32'd0, o_result}, {32'd0, m_res});
        chk("model_o_tag", {58'd0, o_tag}, {58'd0, m_tag});
      end
    end
    h = m_has; r = m_res; t = m_tag; d = m_due;
    if (rst || i_flush) begin
      h = 1'b0;
    end else begin
      if (ev && i_ready) h = 1'b0;
      if (i_valid && er) begin
        h = 1'b1;
        r = ref_alu(i_op, i_op1, i_op2);
        t = i_tag;
        d = cyc + (((i_op == 4'd10) || (i_op == 4'd11)) ? 33 : 1);
      end
    end
    n_has <= h; n_res <= r; n_tag <= t; n_due <= d;
  end

  // Commit the model state on the DUT's clock edge.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    m_has <= n_has;
    m_res <= n_res;
    m_tag <= n_tag;
    m_due <= n_due;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag);
    i_valid = 1'b1; i_op = op; i_op1 = a; i_op2 = b; i_tag = tag;
  endtask

  task automatic run_alu(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] tag, input logic [31:0] exp);
    issue(op, a, b, tag);
    i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, {63'd0, o_valid}, 64'd1);
    chk({name, "_result"}, {32'd0, o_result}, {32'd0, exp});
    chk({name, "_tag"}, {58'd0, o_tag}, {58'd0, tag});
    tick();
  endtask

  // Returns at the negedge where o_valid is first seen; n = cycles since accept.
  task automatic wait_valid(output int n, output bit ready_seen);
    ready_seen = 1'b0;
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      n = k;
      @(negedge clk);
      if (o_valid) break;
      if (o_ready) ready_seen = 1'b1;
      n = 101;
      tick();
    end
  endtask

  task automatic run_mul(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int n;
    bit rs;
    issue(op, a, b, 6'd17);
    i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    wait_valid(n, rs);
    chk({name, "_latency"}, 64'(n), 64'd33);
    chk({name, "_ready_in_busy"}, {63'd0, rs}, 64'd0);
    chk({name, "_result"}, {32'd0, o_result}, {32'd0, exp});
    tick();
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       rnd_operand = 32'hFFFF_FFFF;
      1:       rnd_operand = 32'h8000_0000;
      2:       rnd_operand = 32'd0;
      3:       rnd_operand = 32'd1;
      default: rnd_operand = $urandom;
    endcase
  endfunction

  initial begin
    bit bad;
    int n;
    bit rs;
    rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_op = 4'd0;
    i_op1 = 32'd0; i_op2 = 32'd0; i_tag = 6'd0; i_ready = 1'b0;

    // Pin the reference model itself with hand-computed values.
    chk("ref_add_wrap", {32'd0, ref_alu(4'd0, 32'hFFFF_FFFF, 32'd1)}, 64'd0);
    chk("ref_sra", {32'd0, ref_alu(4'd7, 32'h8000_0000, 32'h24)}, 64'hF800_0000);
    chk("ref_mulhu", {32'd0, ref_alu(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF)}, 64'hFFFF_FFFE);
    chk("ref_slt", {32'd0, ref_alu(4'd8, 32'hFFFF_FFFF, 32'd1)}, 64'd1);

    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_o_valid", {63'd0, o_valid}, 64'd0);
    chk("reset_o_ready", {63'd0, o_ready}, 64'd1);
    tick();

    run_alu("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 6'd5, 32'd0);
    run_alu("sra", 4'd7, 32'h8000_0000, 32'h24, 6'd6, 32'hF800_0000);
    run_alu("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 6'd7, 32'd1);
    run_alu("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 6'd8, 32'd0);
    run_alu("reserved", 4'd13, 32'h1234_5678, 32'd9, 6'd11, 32'd0);
    run_mul("mul", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    run_mul("mulhu", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // Hold a result for 5 cycles, then retire it while issuing back-to-back.
    issue(4'd0, 32'd7, 32'd8, 6'd9);
    i_ready = 1'b0;
    tick();
    i_valid = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (o_valid !== 1'b1 || o_result !== 32'd15 || o_tag !== 6'd9 || o_ready !== 1'b0)
        bad = 1'b1;
      tick();
    end
    chk("hold_stable", {63'd0, bad}, 64'd0);
    issue(4'd0, 32'd1, 32'd2, 6'd10);
    i_ready = 1'b1;
    @(negedge clk);
    chk("b2b_ready", {63'd0, o_ready}, 64'd1);
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", {63'd0, o_valid}, 64'd1);
    chk("b2b_result", {32'd0, o_result}, 64'd3);
    chk("b2b_tag", {58'd0, o_tag}, 64'd10);
    tick();

    // Flush a multiply at its 10th BUSY cycle.
    issue(4'd10, 32'd3, 32'd4, 6'd12);
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    @(negedge clk);
    chk("flush_ready", {63'd0, o_ready}, 64'd1);
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("flush_no_valid", {63'd0, bad}, 64'd0);
    run_alu("post_flush_add", 4'd0, 32'd2, 32'd3, 6'd13, 32'd5);

    // Reset while holding a result.
    issue(4'd0, 32'd4, 32'd4, 6'd14);
    i_ready = 1'b0;
    tick();
    i_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_done_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_done_ready", {63'd0, o_ready}, 64'd1);
    tick();

    // Randomized mixed stream; the model process checks every cycle.
    for (int k = 0; k < 3000; k++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_op    = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15))
                                            : 4'($urandom_range(0, 9));
      i_op1   = rnd_operand();
      i_op2   = rnd_operand();
      i_tag   = 6'($urandom);
      i_ready = ($urandom_range(0, 2) != 0);
      i_flush = ($urandom_range(0, 59) == 0);
      rst     = ($urandom_range(0, 249) == 0);
      tick();
    end
    i_valid = 1'b0; i_flush = 1'b0; rst = 1'b0; i_ready = 1'b1;
    for (int k = 0; k < 40; k++) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
